mem_port_arbiter: RTL and testbench

- Shares one single-port 1024x32 memory between the IF-stage instruction fetch requester and the MEM-stage load/store requester of the 32-bit pipelined processor.
- Arbitrates once per cycle. Data accesses have priority; a starvation guard protects fetch.
- Drives the memory's address, enable and write controls, and steers the 1-cycle-latency read data back to the winning requester.
- Provides a flush hook that drops a fetch in flight on a taken branch, a halt hook, and a saturating conflict counter.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the port arbiter and the
// single-port memory. The arbiter takes the slave view; the requester side takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // Fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  // Load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Memory macro side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store:
// data has priority, a streak limit keeps fetch from starving, reads return one cycle later.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 3,
  parameter int CNT_W      = 16
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus,
  input  logic                 flush,
  input  logic                 halt,
  output logic [CNT_W-1:0]     conflict_cnt
);

  localparam int STREAK_W = $clog2(STREAK_MAX + 1);

  logic                i_gnt;
  logic                d_gnt;
  logic                streak_lt_max;
  logic                conflict;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   rdata;

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                pend_i_q, pend_i_d;
  logic                pend_d_q, pend_d_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;

  assign streak_lt_max = (streak_q < STREAK_W'(STREAK_MAX));
  assign conflict      = bus.i_req & bus.d_req & ~halt;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    streak_d = streak_q;
    cnt_d    = cnt_q;

    if (!halt) begin
      // Flush squashes the fetch side, which hands the slot to data even past the streak limit.
      if (bus.d_req && (!bus.i_req || flush || streak_lt_max)) begin
        d_gnt = 1'b1;
      end else if (bus.i_req && !flush) begin
        i_gnt = 1'b1;
      end
    end

    // Streak only counts data wins that actually made fetch wait; capped so a flush cannot push it past the limit.
    if (i_gnt || !bus.i_req) begin
      streak_d = '0;
    end else if (d_gnt && streak_lt_max) begin
      streak_d = streak_q + STREAK_W'(1);
    end

    if (conflict && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    pend_i_d = i_gnt;
    pend_d_d = d_gnt & ~bus.d_we;
  end

  // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
      pend_i_q <= 1'b0;
      pend_d_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      streak_q <= streak_d;
      pend_i_q <= pend_i_d;
      pend_d_q <= pend_d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign addr_sel      = d_gnt ? bus.d_addr : bus.i_addr;
  assign rdata         = bus.mem_rdata;

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = i_gnt | d_gnt;
  assign bus.mem_we    = d_gnt & bus.d_we;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = bus.d_wdata;

  // A flush in the response cycle drops the fetch that was already in flight.
  assign bus.i_rvalid  = pend_i_q & ~flush;
  assign bus.d_rvalid  = pend_d_q;
  assign bus.i_rdata   = rdata;
  assign bus.d_rdata   = rdata;

  assign conflict_cnt  = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a behavioural memory behind the port,
// expected read data queued at grant time and checked when rvalid appears.
module tb_mem_port_arbiter;

  logic        clk1;
  logic        rst_n;
  logic        flush;
  logic        halt;
  logic [15:0] conflict_cnt;
  logic [3:0]  conflict_cnt4;

  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus  ();
  mem_port_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus4 ();

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STREAK_MAX(3), .CNT_W(16)) dut (
    .clk1(clk1), .rst_n(rst_n), .bus(bus.slave),
    .flush(flush), .halt(halt), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance sees the same requests, used for saturation.
  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .STREAK_MAX(3), .CNT_W(4)) dut4 (
    .clk1(clk1), .rst_n(rst_n), .bus(bus4.slave),
    .flush(flush), .halt(halt), .conflict_cnt(conflict_cnt4)
  );

  assign bus4.i_req     = bus.i_req;
  assign bus4.i_addr    = bus.i_addr;
  assign bus4.d_req     = bus.d_req;
  assign bus4.d_we      = bus.d_we;
  assign bus4.d_addr    = bus.d_addr;
  assign bus4.d_wdata   = bus.d_wdata;
  assign bus4.mem_rdata = '0;

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Behavioural 1024x32 memory; unwritten words read as DEAD0000 | address.
  logic [31:0] mem     [0:1023];
  logic        written [0:1023];
  logic [31:0] rdata_q;

  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]     <= bus.mem_wdata;
        written[bus.mem_addr] <= 1'b1;
      end else begin
        rdata_q <= (written[bus.mem_addr] === 1'b1) ? mem[bus.mem_addr]
                                                    : (32'hDEAD0000 | {22'd0, bus.mem_addr});
      end
    end
  end
  assign bus.mem_rdata = rdata_q;

  int          total;
  int          bad;
  int          exp_cnt;
  int          exp_cnt4;
  logic        exp_pi;
  logic        exp_pd;
  logic [31:0] ref_mem [0:1023];
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs, input logic do_cmp);
    logic [31:0] e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s: scoreboard empty, observed=%0h", tag, obs);
    end else begin
      e = sb.pop_front();
      if (do_cmp) check(tag, obs, e);
    end
  endtask

  // One cycle: drive at negedge, check responses owed from the previous cycle, then this cycle's grants.
  task automatic step(input logic ir, input logic [9:0] ia,
                      input logic dr, input logic dwe, input logic [9:0] da, input logic [31:0] dw,
                      input logic fl, input logic hl, input logic eig, input logic edg);
    @(negedge clk1);
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dw;
    flush       = fl;
    halt        = hl;
    #1;
    check("conflict_cnt", {16'd0, conflict_cnt}, exp_cnt);
    check("conflict_cnt4", {28'd0, conflict_cnt4}, exp_cnt4);
    check("i_rvalid", {31'd0, bus.i_rvalid}, {31'd0, exp_pi & ~fl});
    if (exp_pi) pop_check("i_rdata", bus.i_rdata, !fl);
    check("d_rvalid", {31'd0, bus.d_rvalid}, {31'd0, exp_pd});
    if (exp_pd) pop_check("d_rdata", bus.d_rdata, 1'b1);
    check("i_gnt", {31'd0, bus.i_gnt}, {31'd0, eig});
    check("d_gnt", {31'd0, bus.d_gnt}, {31'd0, edg});
    check("mem_en", {31'd0, bus.mem_en}, {31'd0, eig | edg});
    check("mem_we", {31'd0, bus.mem_we}, {31'd0, edg & dwe});
    if (eig | edg) check("mem_addr", {22'd0, bus.mem_addr}, {22'd0, edg ? da : ia});
    if (edg & dwe) check("mem_wdata", bus.mem_wdata, dw);

    exp_pi = eig;
    exp_pd = edg & ~dwe;
    if (eig)        sb.push_back(ref_mem[ia]);
    if (edg & ~dwe) sb.push_back(ref_mem[da]);
    if (edg & dwe)  ref_mem[da] = dw;
    if (ir & dr & ~hl) begin
      if (exp_cnt  < 65535) exp_cnt++;
      if (exp_cnt4 < 15)    exp_cnt4++;
    end
  endtask

  task automatic idle();
    step(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    exp_cnt  = 0;
    exp_cnt4 = 0;
    exp_pi   = 1'b0;
    exp_pd   = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'hDEAD0000 | i;

    rst_n       = 1'b0;
    flush       = 1'b0;
    halt        = 1'b0;
    bus.i_req   = 1'b0;
    bus.i_addr  = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;

    // Reset, then idle
    repeat (3) @(posedge clk1);
    #1;
    check("rst_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
    check("rst_d_rvalid", {31'd0, bus.d_rvalid}, 32'd0);
    check("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    check("rst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    idle();
    idle();

    // Single fetch of word 5
    step(1'b1, 10'h005, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Store to word 9, then load it back
    step(1'b0, 10'd0, 1'b1, 1'b1, 10'd9, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 10'd0, 1'b1, 1'b0, 10'd9, 32'd0,    1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    // Starvation guard: both requests for 8 cycles -> D,D,D,I,D,D,D,I
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 10'd7, 1'b1, 1'b0, 10'd8, 32'd0, 1'b0, 1'b0, (k % 4) == 3, (k % 4) != 3);
    end
    idle();

    // Flush: fetch granted, squashed next cycle, re-granted once flush drops
    step(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    // Flush with both requests hands the slot to data
    step(1'b1, 10'd4, 1'b1, 1'b0, 10'd6, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle();

    // Halt holds the streak: D,D, halted x3, then D (third) and I
    step(1'b1, 10'd11, 1'b1, 1'b0, 10'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'd11, 1'b1, 1'b0, 10'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 10'd11, 1'b1, 1'b0, 10'd12, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 10'd11, 1'b1, 1'b0, 10'd12, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'd11, 1'b1, 1'b0, 10'd12, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    // Read granted just before halt rises still returns
    step(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();

    // Saturation of the 4-bit counter over 20 conflict cycles
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 10'd20, 1'b1, 1'b0, 10'd21, 32'd0, 1'b0, 1'b0, (k % 4) == 3, (k % 4) != 3);
    end
    idle();
    check("cnt4_saturated", {28'd0, conflict_cnt4}, 32'hF);

    // Reset with a fetch response pending: no rvalid afterwards
    step(1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk1);
    bus.i_req = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst_i_rvalid", {31'd0, bus.i_rvalid}, 32'd0);
    check("midrst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    exp_pi   = 1'b0;
    exp_pd   = 1'b0;
    exp_cnt  = 0;
    exp_cnt4 = 0;
    sb.delete();
    @(posedge clk1);
    #1;
    rst_n = 1'b1;
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
